// File: rtl/dmem_bridge_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the data-memory bridge: FSM state encoding
// and access-size decoding.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [3:0] size_bytes(input logic [1:0] mem_size);
    logic [3:0] nbytes;
    case (mem_size)
      SZ_B:    nbytes = 4'd1;
      SZ_H:    nbytes = 4'd2;
      SZ_W:    nbytes = 4'd4;
      SZ_D:    nbytes = 4'd8;
      default: nbytes = 4'd8;
    endcase
    return nbytes;
  endfunction

endpackage

// File: rtl/dmem_bridge_lane_align.sv
`timescale 1ns/1ps
// Byte-lane steering between right-justified datapath values and the
// 64-bit bus: strobes, store/load shifts and alignment check.
module lane_align
  import dmem_bridge_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  mem_size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_sh,
  output logic        misaligned
);

  logic [3:0] bytes_s;
  logic [5:0] bit_off_s;
  logic [7:0] strb_base_s;

  // lane shifts, strobes and alignment for the current offset/size
  always_comb begin
    bytes_s     = size_bytes(mem_size);
    bit_off_s   = {addr_lo, 3'b000};
    strb_base_s = 8'((16'd1 << bytes_s) - 16'd1);
    wstrb       = strb_base_s << addr_lo;
    wdata_sh    = wdata << bit_off_s;
    rdata_sh    = rdata >> bit_off_s;
    // any set offset bit below the size boundary means misaligned
    misaligned  = (({1'b0, addr_lo}) & (bytes_s - 4'd1)) != 4'd0;
  end

endmodule

// File: rtl/dmem_bridge.sv
`timescale 1ns/1ps
// Data-memory bridge: turns the datapath's single-cycle load/store strobes
// into a valid/ready bus transaction and stalls the core until it completes.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 255,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  DM_addr,
  input  logic [N-1:0]  DM_writeData,
  input  logic          DM_writeEnable,
  input  logic          DM_readEnable,
  input  logic [1:0]    memSize,
  output logic [N-1:0]  DM_readData,
  output logic          stall,
  output logic          fault,
  output logic          bus_valid,
  input  logic          bus_ready,
  output logic          bus_we,
  output logic [N-1:0]  bus_addr,
  output logic [63:0]   bus_wdata,
  output logic [7:0]    bus_wstrb,
  input  logic          bus_rvalid,
  input  logic [63:0]   bus_rdata
);

  state_t        state_r;
  state_t        next_state_s;
  logic [N-1:0]  addr_r;
  logic [63:0]   wdata_r;
  logic [7:0]    wstrb_r;
  logic          we_r;
  logic          valid_r;
  logic          fault_r;
  logic [N-1:0]  rdata_r;
  logic [TW-1:0] cnt_r;

  logic          req_s;
  logic          accept_s;
  logic          timeout_s;
  logic          latch_s;
  logic          set_fault_s;
  logic          capture_s;
  logic [2:0]    addr_lo_s;
  logic [7:0]    wstrb_s;
  logic [63:0]   wdata_sh_s;
  logic [63:0]   rdata_sh_s;
  logic          misaligned_s;

  assign req_s     = DM_writeEnable | DM_readEnable;
  assign accept_s  = valid_r & bus_ready;
  assign timeout_s = (cnt_r >= TW'(TIMEOUT - 1));
  // Before latching, steer from the live address; afterwards from the held copy.
  assign addr_lo_s = (state_r == IDLE) ? DM_addr[2:0] : addr_r[2:0];

  lane_align u_lane_align (
    .addr_lo    (addr_lo_s),
    .mem_size   (memSize),
    .wdata      (64'(DM_writeData)),
    .rdata      (bus_rdata),
    .wstrb      (wstrb_s),
    .wdata_sh   (wdata_sh_s),
    .rdata_sh   (rdata_sh_s),
    .misaligned (misaligned_s)
  );

  // next-state and per-cycle control strobes
  always_comb begin
    next_state_s = state_r;
    latch_s      = 1'b0;
    set_fault_s  = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (misaligned_s) begin
            set_fault_s  = 1'b1;
            next_state_s = DONE;
          end else begin
            latch_s      = 1'b1;
            next_state_s = REQ;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (accept_s) begin
          next_state_s = we_r ? DONE : RDATA;
        end else if (timeout_s) begin
          set_fault_s  = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = REQ;
        end
      end
      RDATA: begin
        if (bus_rvalid) begin
          capture_s    = 1'b1;
          next_state_s = DONE;
        end else if (timeout_s) begin
          set_fault_s  = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = RDATA;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // transaction latches, timeout counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r  <= {N{1'b0}};
      wdata_r <= 64'd0;
      wstrb_r <= 8'd0;
      we_r    <= 1'b0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
      rdata_r <= {N{1'b0}};
      cnt_r   <= {TW{1'b0}};
    end else begin
      valid_r <= (next_state_s == REQ);
      // fault and load data are only ever non-zero for the single DONE cycle
      fault_r <= set_fault_s;
      rdata_r <= capture_s ? N'(rdata_sh_s) : {N{1'b0}};
      if (latch_s) begin
        addr_r  <= DM_addr;
        wdata_r <= wdata_sh_s;
        wstrb_r <= wstrb_s;
        we_r    <= DM_writeEnable;
        cnt_r   <= {TW{1'b0}};
      end else if ((state_r == REQ) || (state_r == RDATA)) begin
        cnt_r <= (cnt_r == TW'(TIMEOUT)) ? cnt_r : cnt_r + TW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Gated by reset so the core is released the instant reset asserts.
  assign stall       = req_s & (state_r != DONE) & ~reset;
  assign fault       = fault_r;
  assign DM_readData = rdata_r;
  assign bus_valid   = valid_r;
  assign bus_we      = we_r;
  assign bus_addr    = {addr_r[N-1:3], 3'b000};
  assign bus_wdata   = wdata_r;
  assign bus_wstrb   = wstrb_r;

endmodule

// File: tb/tb_dmem_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for dmem_bridge: directed scenarios plus randomized
// accesses against a latency/data model derived from the access rules.
module tb_dmem_bridge;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] DM_addr, DM_writeData, DM_readData;
  logic        DM_writeEnable, DM_readEnable;
  logic [1:0]  memSize;
  logic        stall, fault;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;

  int checks   = 0;
  int failures = 0;

  dmem_bridge #(.N(64), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .DM_addr(DM_addr), .DM_writeData(DM_writeData),
    .DM_writeEnable(DM_writeEnable), .DM_readEnable(DM_readEnable),
    .memSize(memSize), .DM_readData(DM_readData),
    .stall(stall), .fault(fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    DM_addr = 64'd0; DM_writeData = 64'd0;
    DM_writeEnable = 1'b0; DM_readEnable = 1'b0; memSize = 2'd0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 64'd0;
  endtask

  // One access entered at a negedge. The bus responder raises ready after
  // rdy_d cycles of bus_valid and rvalid rv_d cycles after the accept.
  task automatic access(input string tag, input logic we, input logic re,
                        input logic [1:0] sz, input logic [63:0] addr,
                        input logic [63:0] wd, input int rdy_d, input int rv_d,
                        input logic [63:0] rd);
    int          nbytes, off, done_cyc, vlast, lim;
    logic        mis, tmo, exp_valid;
    logic [15:0] m;
    logic [7:0]  exp_strb;
    logic [63:0] exp_rd;
    nbytes   = 1 << sz;
    off      = int'(addr[2:0]);
    mis      = (off % nbytes) != 0;
    m        = ((16'd1 << nbytes) - 16'd1) << off;
    exp_strb = m[7:0];
    exp_rd   = 64'd0;
    tmo      = 1'b0;
    if (mis) begin
      done_cyc = 1; vlast = 0;
    end else if (rdy_d > T - 1) begin
      done_cyc = T + 1; vlast = T; tmo = 1'b1;
    end else begin
      vlast = 1 + rdy_d;
      if (we) begin
        done_cyc = 2 + rdy_d;
      end else begin
        lim = (T - 1 > rdy_d + 1) ? T - 1 : rdy_d + 1;
        if (rdy_d + rv_d <= lim) begin
          done_cyc = 2 + rdy_d + rv_d;
          exp_rd   = rd >> (8 * off);
        end else begin
          done_cyc = 2 + lim; tmo = 1'b1;
        end
      end
    end
    DM_addr = addr; DM_writeData = wd; memSize = sz;
    DM_writeEnable = we; DM_readEnable = re;
    for (int c = 0; c <= done_cyc; c++) begin
      #1;
      exp_valid = (c >= 1) && (c <= vlast);
      if (c < done_cyc) begin
        chk({tag, ":stall"}, 64'(stall), 64'd1);
        chk({tag, ":rdata_busy"}, DM_readData, 64'd0);
        chk({tag, ":valid"}, 64'(bus_valid), 64'(exp_valid));
        if (exp_valid) begin
          chk({tag, ":addr"}, bus_addr, {addr[63:3], 3'b000});
          chk({tag, ":we"}, 64'(bus_we), 64'(we));
          if (we) begin
            chk({tag, ":wdata"}, bus_wdata, wd << (8 * off));
            chk({tag, ":wstrb"}, 64'(bus_wstrb), 64'(exp_strb));
          end
        end
      end else begin
        chk({tag, ":stall_done"}, 64'(stall), 64'd0);
        chk({tag, ":fault"}, 64'(fault), 64'(mis | tmo));
        chk({tag, ":rdata"}, DM_readData, exp_rd);
        chk({tag, ":valid_done"}, 64'(bus_valid), 64'd0);
      end
      bus_ready  = !mis && (c == 1 + rdy_d);
      bus_rvalid = bus_ready ? 1'b1 : (!we && !mis && (c == 1 + rdy_d + rv_d));
      bus_rdata  = bus_ready ? {$urandom, $urandom} : rd;
      @(negedge clk);
    end
    clear_inputs();
    // idle gap with bus noise that must be ignored
    bus_ready  = 1'($urandom_range(1, 0));
    bus_rvalid = 1'($urandom_range(1, 0));
    bus_rdata  = {$urandom, $urandom};
    #1;
    chk({tag, ":idle_stall"}, 64'(stall), 64'd0);
    chk({tag, ":idle_valid"}, 64'(bus_valid), 64'd0);
    chk({tag, ":idle_fault"}, 64'(fault), 64'd0);
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    logic        we, re;
    logic [1:0]  sz;
    logic [2:0]  a3, m3;
    logic [63:0] addr;

    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst:valid", 64'(bus_valid), 64'd0);
    chk("rst:stall", 64'(stall), 64'd0);
    chk("rst:fault", 64'(fault), 64'd0);
    chk("rst:rdata", DM_readData, 64'd0);
    chk("rst:wstrb", 64'(bus_wstrb), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    access("dwr",  1'b1, 1'b0, 2'd3, 64'h1000, 64'h1122334455667788, 0, 1, 64'd0);
    access("brd",  1'b0, 1'b1, 2'd0, 64'h2005, 64'd0, 0, 1, 64'hAABBCCDDEEFF0011);
    access("hmis", 1'b1, 1'b0, 2'd1, 64'h3001, 64'h1234, 0, 1, 64'd0);
    access("wtmo", 1'b0, 1'b1, 2'd2, 64'h4004, 64'd0, 10, 1, 64'h55);
    access("wwr",  1'b1, 1'b0, 2'd2, 64'h5004, 64'hDEADBEEF, 3, 1, 64'd0);
    access("both", 1'b1, 1'b1, 2'd1, 64'h5102, 64'hBEEF, 1, 1, 64'hFFFF);
    access("rdtmo", 1'b0, 1'b1, 2'd3, 64'h5200, 64'd0, 1, 4, 64'h77);

    // asynchronous reset while waiting for read data
    DM_addr = 64'h6010; memSize = 2'd3; DM_readEnable = 1'b1;
    @(negedge clk);
    bus_ready = 1'b1;
    #1;
    chk("arst:valid_pre", 64'(bus_valid), 64'd1);
    @(negedge clk);
    bus_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst:valid", 64'(bus_valid), 64'd0);
    chk("arst:stall", 64'(stall), 64'd0);
    chk("arst:fault", 64'(fault), 64'd0);
    @(negedge clk);
    DM_readEnable = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("arst:idle_stall", 64'(stall), 64'd0);
    chk("arst:idle_valid", 64'(bus_valid), 64'd0);
    @(negedge clk);
    access("arst_rd", 1'b0, 1'b1, 2'd3, 64'h6010, 64'd0, 0, 2, 64'h0102030405060708);

    for (int i = 0; i < 40; i++) begin
      sz   = 2'($urandom_range(3, 0));
      we   = 1'($urandom_range(1, 0));
      re   = we ? 1'($urandom_range(1, 0)) : 1'b1;
      addr = {$urandom, $urandom};
      a3   = 3'($urandom_range(7, 0));
      m3   = 3'((1 << sz) - 1);
      if ($urandom_range(3, 0) != 0) a3 = a3 & ~m3;
      addr[2:0] = a3;
      access("rnd", we, re, sz, addr, {$urandom, $urandom},
             $urandom_range(5, 0), $urandom_range(5, 1), {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory bridge directly downstream of the single-cycle 64-bit datapath.
- Consumes the datapath's DM_addr / DM_writeData / DM_writeEnable / DM_readEnable and runs a multi-cycle valid/ready memory bus transaction.
- Asserts stall to freeze PC and register-file writes until the access completes.
- Returns lane-aligned read data (requested bytes in low bits) to the datapath's memory-mask logic, and flags misaligned or timed-out accesses.

Parameters:
N, 64, datapath address/data width (bus data fixed at 64 bits)
TIMEOUT, 255, max cycles waiting in REQ or RDATA before abort
TW, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
DM_addr  in  N  byte address from execute stage
DM_writeData  in  N  store data, right-justified (low bytes)
DM_writeEnable  in  1  store request
DM_readEnable  in  1  load request
memSize  in  2  access size: 0=byte 1=half 2=word 3=double
DM_readData  out  N  load data shifted right by addr[2:0]*8; 0 except in DONE
stall  out  1  freeze core while access is pending
fault  out  1  misaligned/timeout flag, valid in DONE only
bus_valid  out  1  request valid
bus_ready  in  1  request accepted
bus_we  out  1  1=write 0=read
bus_addr  out  N  DM_addr with bits [2:0] cleared
bus_wdata  out  64  store data shifted left by addr[2:0]*8
bus_wstrb  out  8  byte strobes: ((1<<bytes)-1) << addr[2:0]
bus_rvalid  in  1  read data valid
bus_rdata  in  64  read beat

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - State = IDLE.
  - All registers 0.
  - bus_valid, stall, fault, DM_readData, bus_wstrb = 0.
  - bus_valid drops immediately on reset assertion, including mid-transaction.
- Request definition: req = DM_writeEnable | DM_readEnable.
  - If both are asserted, the access is treated as a write.
  - Inputs are held stable by the core while stall=1.
- Stall: combinational, stall = req & (state != DONE).
- Misalignment: an access is misaligned when DM_addr mod size-in-bytes != 0.
- FSM states: IDLE, REQ, RDATA, DONE.
  - IDLE, req=0: stay in IDLE.
  - IDLE, req=1 and aligned: latch bus_addr, wdata, wstrb, we; clear the timeout counter; go to REQ.
  - IDLE, req=1 and misaligned: set the fault register; go to DONE. No bus activity.
  - REQ: bus_valid=1 driven from registered values.
    - On bus_valid & bus_ready: a write goes to DONE; a read goes to RDATA.
    - If the counter reaches TIMEOUT first: set fault, drop bus_valid, go to DONE.
  - RDATA: bus_valid=0.
    - On bus_rvalid: capture bus_rdata >> (addr[2:0]*8); go to DONE.
    - If the counter reaches TIMEOUT first: set fault, load data 0, go to DONE.
    - bus_rvalid arriving in the same cycle as the accept is ignored; rvalid earliest one cycle after accept.
  - DONE: lasts exactly one cycle.
    - stall=0.
    - DM_readData = captured data (0 on fault or write).
    - fault = registered fault flag.
    - Next state IDLE; fault register clears.
- Timeout counter: increments each cycle in REQ/RDATA, saturates, and resets when entering REQ.
- Minimum latencies (request in cycle 0):
  - Write: 3 cycles; commit in cycle 2 when bus_ready=1 in cycle 1.
  - Read: 4 cycles; rvalid in cycle 2, commit in cycle 3.
  - Misaligned: 2 cycles.
- Back-to-back accesses: a new req in the cycle after DONE starts a fresh transaction from IDLE. No request is lost and none is issued twice.
- bus_rvalid or bus_ready while in IDLE/DONE: ignored.

Decomposition:
- Package dmem_bridge_pkg:
  - state_t enum {IDLE, REQ, RDATA, DONE}.
  - Size constants SZ_B, SZ_H, SZ_W, SZ_D.
  - Function size_bytes(memSize).
- Sub-module lane_align (combinational): inputs addr[2:0], memSize, wdata, rdata; outputs wstrb, shifted wdata, shifted rdata, misaligned.
- FSM, latches and counter live in dmem_bridge.

Test Plan:
- Double write, addr 0x1000, data 0x1122334455667788, ready=1 in cycle 1:
  - bus_addr=0x1000, wstrb=0xFF, wdata unchanged.
  - stall high cycles 0–1, low cycle 2, fault=0.
- Byte read, addr 0x2005, bus_rdata=0xAABBCCDDEEFF0011 rvalid cycle 2:
  - bus_addr=0x2000, wstrb ignored.
  - DM_readData=0x0000AABBCC in low bytes (0x0000000000AABBCC) in cycle 3.
- Half write, addr 0x3001:
  - No bus_valid.
  - stall=1 in cycle 0; cycle 1: stall=0, fault=1, DM_readData=0.
- Word read, addr 0x4004, TIMEOUT=4, bus_ready held 0:
  - bus_valid for 4 cycles, then dropped.
  - DONE with fault=1, DM_readData=0.
- Word write, addr 0x5004, data 0xDEADBEEF:
  - wstrb=0xF0, wdata=0xDEADBEEF00000000.
  - ready delayed 3 cycles → commit 1 cycle after accept.
- Read in RDATA, assert reset asynchronously mid-cycle:
  - bus_valid/stall/fault = 0 immediately.
  - After release: IDLE; a following read completes normally.
